// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle control sequencer for the 8-bit processor datapath. Steps each
//   instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the enables
//   and mux selects of the PC, IR, register file, ALU, immediate path and memory
//   port. It holds no data values; it reads the IR contents and the ALU zero flag.
//
//   Optional feature macro: MULTICYCLE_MEM_HANDSHAKE_EN
//     defined     : FETCH and MEM hold until mem_ack is seen.
//     not defined : mem_ack is ignored (treated as 1); FETCH and MEM each take
//                   exactly one cycle and mem_req is a one-cycle strobe.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   run          level; 1 permits instruction issue
//   instr[7:0]   IR contents: op[7:5], ra[4:3], imm3[2:0]
//   zero         ALU zero flag (used in EXEC of BEQZ)
//   mem_ack      memory completion for the current mem_req
//   pc_we        PC load enable
//   pc_src       0 = PC+1, 1 = PC+sext(imm3)
//   ir_we        IR load enable
//   rf_we        register-file write enable (dest ra)
//   wb_sel       0 = ALU result, 1 = memory read data
//   alu_op[1:0]  00 ADD, 01 SUB, 10 AND, 11 PASS-A
//   alu_src_imm  ALU B operand: 0 = reg, 1 = sext(imm3)
//   mem_req      memory request
//   mem_we       memory write (valid with mem_req)
//   addr_sel     memory address: 0 = PC, 1 = ALU result
//   halted       HALT executed (sticky until reset)
//   state[2:0]   current FSM state code
//   retired      instructions completed, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [7:0]       instr,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             pc_we,
  output logic             pc_src,
  output logic             ir_we,
  output logic             rf_we,
  output logic             wb_sel,
  output logic [1:0]       alu_op,
  output logic             alu_src_imm,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_ADDI = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_BEQZ = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire_d;
  logic             ack;
  logic [2:0]       op;

  // ra and imm3 are consumed by the datapath, not by the sequencer.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[4:0];

`ifdef MULTICYCLE_MEM_HANDSHAKE_EN
  assign ack = mem_ack;
`else
  logic unused_mem_ack;
  assign unused_mem_ack = mem_ack;
  assign ack = 1'b1;
`endif

  assign op = instr[7:5];

  // Enables and selects are decoded combinationally from the current state,
  // the IR and the ack so that they act on the very next rising edge.
  always_comb begin
    state_d     = state_q;
    retire_d    = 1'b0;
    pc_we       = 1'b0;
    pc_src      = 1'b0;
    ir_we       = 1'b0;
    rf_we       = 1'b0;
    wb_sel      = 1'b0;
    alu_op      = 2'b00;
    alu_src_imm = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (ack) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND: begin
            alu_op  = op[1:0];
            state_d = S_WB;
          end
          OP_ADDI: begin
            alu_src_imm = 1'b1;
            state_d     = S_WB;
          end
          OP_LD, OP_ST: begin
            // Effective address is ra + sext(imm3) through the ALU.
            alu_src_imm = 1'b1;
            state_d     = S_MEM;
          end
          OP_BEQZ: begin
            alu_op = 2'b11;
            if (zero) begin
              pc_we  = 1'b1;
              pc_src = 1'b1;
            end
            retire_d = 1'b1;
            state_d  = run ? S_FETCH : S_IDLE;
          end
          default: begin // OP_HALT
            retire_d = 1'b1;
            state_d  = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        // Keep the address path steering ra + imm while the access is open.
        mem_req     = 1'b1;
        addr_sel    = 1'b1;
        alu_src_imm = 1'b1;
        mem_we      = (op == OP_ST);
        if (ack) begin
          if (op == OP_LD) begin
            state_d = S_WB;
          end else begin
            retire_d = 1'b1;
            state_d  = run ? S_FETCH : S_IDLE;
          end
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        wb_sel   = (op == OP_LD);
        retire_d = 1'b1;
        state_d  = run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire_d) retired_q <= retired_q + 1'b1;
    end
  end

  assign halted  = (state_q == S_HALT);
  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Cycle-by-cycle bench for multicycle_ctrl. Each cycle drives run/instr/zero/
//   mem_ack, pushes the expected {state, controls, retired} to a queue, and at
//   the falling edge pops it and compares against the DUT.
//   Control vector packing: {pc_we, pc_src, ir_we, rf_we, wb_sel, alu_op[1:0],
//   alu_src_imm, mem_req, mem_we, addr_sel, halted}.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [7:0] instr;
  logic       zero;
  logic       mem_ack;
  logic       pc_we, pc_src, ir_we, rf_we, wb_sel;
  logic [1:0] alu_op;
  logic       alu_src_imm, mem_req, mem_we, addr_sel, halted;
  logic [2:0] state;
  logic [7:0] retired;

  multicycle_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instr(instr), .zero(zero),
    .mem_ack(mem_ack), .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we),
    .rf_we(rf_we), .wb_sel(wb_sel), .alu_op(alu_op),
    .alu_src_imm(alu_src_imm), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .halted(halted), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DEC = 3'd2, EXEC = 3'd3,
                         MEM = 3'd4, WB = 3'd5, HALT = 3'd6;

  localparam logic [11:0] C_NONE  = 12'b0000_0000_0000;
  localparam logic [11:0] C_FACK  = 12'b1010_0000_1000;
  localparam logic [11:0] C_FWAIT = 12'b0000_0000_1000;
  localparam logic [11:0] C_ESUB  = 12'b0000_0010_0000;
  localparam logic [11:0] C_EAND  = 12'b0000_0100_0000;
  localparam logic [11:0] C_EIMM  = 12'b0000_0001_0000;
  localparam logic [11:0] C_EBZ   = 12'b1100_0110_0000;
  localparam logic [11:0] C_EBNZ  = 12'b0000_0110_0000;
  localparam logic [11:0] C_MLD   = 12'b0000_0001_1010;
  localparam logic [11:0] C_MST   = 12'b0000_0001_1110;
  localparam logic [11:0] C_WALU  = 12'b0001_0000_0000;
  localparam logic [11:0] C_WLD   = 12'b0001_1000_0000;
  localparam logic [11:0] C_HALT  = 12'b0000_0000_0001;

  typedef struct {
    bit         r;
    logic [7:0] ins;
    bit         z;
    bit         ack;
    logic [2:0] es;
    logic [11:0] ec;
    logic [7:0] er;
  } vec_t;

  typedef struct {
    logic [2:0]  es;
    logic [11:0] ec;
    logic [7:0]  er;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   nstep = 0;

  function automatic logic [11:0] ctrl_now();
    return {pc_we, pc_src, ir_we, rf_we, wb_sel, alu_op, alu_src_imm,
            mem_req, mem_we, addr_sel, halted};
  endfunction

  task automatic add(input bit r, input logic [7:0] ins, input bit z,
                     input bit ack, input logic [2:0] es,
                     input logic [11:0] ec, input logic [7:0] er);
    tbl.push_back('{r, ins, z, ack, es, ec, er});
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input bit r, input logic [7:0] ins, input bit z,
                      input bit ack, input logic [2:0] es,
                      input logic [11:0] ec, input logic [7:0] er);
    exp_t e;
    logic [11:0] c;
    run = r; instr = ins; zero = z; mem_ack = ack;
    sb.push_back('{es, ec, er});
    @(negedge clk);
    e = sb.pop_front();
    c = ctrl_now();
    nstep++;
    $display("[TB] step %0d run=%0b instr=%02h zero=%0b ack=%0b state=%0d ctrl=%03h retired=%0d",
             nstep, r, ins, z, ack, state, c, retired);
    tests++;
    if (state !== e.es) begin
      fails++;
      $display("FAIL step%0d state act=%0d exp=%0d", nstep, state, e.es);
    end
    tests++;
    if (c !== e.ec) begin
      fails++;
      $display("FAIL step%0d ctrl act=%03h exp=%03h", nstep, c, e.ec);
    end
    tests++;
    if (retired !== e.er) begin
      fails++;
      $display("FAIL step%0d retired act=%0d exp=%0d", nstep, retired, e.er);
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    rst_n = 1'b0; run = 1'b1; mem_ack = 1'b1;
    #2;
    $display("[TB] reset state=%0d ctrl=%03h retired=%0d halted=%0b",
             state, ctrl_now(), retired, halted);
    tests++;
    if (state !== IDLE) begin fails++; $display("FAIL reset_state act=%0d exp=0", state); end
    tests++;
    if (ctrl_now() !== C_NONE) begin fails++; $display("FAIL reset_ctrl act=%03h exp=000", ctrl_now()); end
    tests++;
    if (retired !== 8'd0) begin fails++; $display("FAIL reset_retired act=%0d exp=0", retired); end
    tests++;
    if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted act=%0b exp=0", halted); end
    @(negedge clk);
    run = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; instr = 8'h00; zero = 1'b0; mem_ack = 1'b0;

    // ---- Table of zero-wait vectors (valid with or without the handshake) ----
    add(0, 8'h00, 0, 0, IDLE, C_NONE, 0);
    add(0, 8'h00, 0, 1, IDLE, C_NONE, 0);
    add(1, 8'h00, 0, 0, IDLE, C_NONE, 0);
    // ADD
    add(1, 8'h00, 0, 1, FETCH, C_FACK, 0);
    add(1, 8'h00, 0, 0, DEC,   C_NONE, 0);
    add(1, 8'h00, 1, 0, EXEC,  C_NONE, 0);
    add(1, 8'h00, 0, 0, WB,    C_WALU, 0);
    // SUB
    add(1, 8'h20, 0, 1, FETCH, C_FACK, 1);
    add(1, 8'h20, 0, 0, DEC,   C_NONE, 1);
    add(1, 8'h20, 0, 0, EXEC,  C_ESUB, 1);
    add(1, 8'h20, 0, 0, WB,    C_WALU, 1);
    // AND
    add(1, 8'h40, 0, 1, FETCH, C_FACK, 2);
    add(1, 8'h40, 0, 0, DEC,   C_NONE, 2);
    add(1, 8'h40, 0, 0, EXEC,  C_EAND, 2);
    add(1, 8'h40, 0, 0, WB,    C_WALU, 2);
    // ADDI
    add(1, 8'h7F, 0, 1, FETCH, C_FACK, 3);
    add(1, 8'h7F, 0, 0, DEC,   C_NONE, 3);
    add(1, 8'h7F, 0, 0, EXEC,  C_EIMM, 3);
    add(1, 8'h7F, 0, 0, WB,    C_WALU, 3);
    // LD
    add(1, 8'h81, 0, 1, FETCH, C_FACK, 4);
    add(1, 8'h81, 0, 0, DEC,   C_NONE, 4);
    add(1, 8'h81, 0, 0, EXEC,  C_EIMM, 4);
    add(1, 8'h81, 0, 1, MEM,   C_MLD,  4);
    add(1, 8'h81, 0, 0, WB,    C_WLD,  4);
    // ST
    add(1, 8'hA2, 0, 1, FETCH, C_FACK, 5);
    add(1, 8'hA2, 0, 0, DEC,   C_NONE, 5);
    add(1, 8'hA2, 0, 0, EXEC,  C_EIMM, 5);
    add(1, 8'hA2, 0, 1, MEM,   C_MST,  5);
    // BEQZ taken
    add(1, 8'hC7, 0, 1, FETCH, C_FACK, 6);
    add(1, 8'hC7, 0, 0, DEC,   C_NONE, 6);
    add(1, 8'hC7, 1, 0, EXEC,  C_EBZ,  6);
    // BEQZ not taken
    add(1, 8'hC7, 1, 1, FETCH, C_FACK, 7);
    add(1, 8'hC7, 1, 0, DEC,   C_NONE, 7);
    add(1, 8'hC7, 0, 0, EXEC,  C_EBNZ, 7);
    // ST with run dropped in EXEC: finishes, then IDLE
    add(1, 8'hA2, 0, 1, FETCH, C_FACK, 8);
    add(1, 8'hA2, 0, 0, DEC,   C_NONE, 8);
    add(0, 8'hA2, 0, 0, EXEC,  C_EIMM, 8);
    add(0, 8'hA2, 0, 1, MEM,   C_MST,  8);
    add(0, 8'hA2, 0, 1, IDLE,  C_NONE, 9);
    add(1, 8'hA2, 0, 1, IDLE,  C_NONE, 9);
    // HALT, then sticky for 20 cycles regardless of run
    add(1, 8'hE0, 0, 1, FETCH, C_FACK, 9);
    add(1, 8'hE0, 0, 0, DEC,   C_NONE, 9);
    add(1, 8'hE0, 0, 0, EXEC,  C_NONE, 9);
    for (int i = 0; i < 20; i++) add(bit'(i % 2), 8'hE0, 0, 1, HALT, C_HALT, 10);

    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].r, tbl[i].ins, tbl[i].z, tbl[i].ack, tbl[i].es, tbl[i].ec, tbl[i].er);

    // Reset out of HALT
    do_reset();

`ifdef MULTICYCLE_MEM_HANDSHAKE_EN
    // LD with a one-cycle fetch wait and two MEM wait cycles
    step(1, 8'h81, 0, 0, IDLE,  C_NONE,  0);
    step(1, 8'h81, 0, 0, FETCH, C_FWAIT, 0);
    step(1, 8'h81, 0, 1, FETCH, C_FACK,  0);
    step(1, 8'h81, 0, 0, DEC,   C_NONE,  0);
    step(1, 8'h81, 0, 0, EXEC,  C_EIMM,  0);
    step(1, 8'h81, 0, 0, MEM,   C_MLD,   0);
    step(1, 8'h81, 0, 0, MEM,   C_MLD,   0);
    step(1, 8'h81, 0, 1, MEM,   C_MLD,   0);
    step(1, 8'h81, 0, 0, WB,    C_WLD,   0);
    // ST with one MEM wait cycle
    step(1, 8'hA2, 0, 1, FETCH, C_FACK,  1);
    step(1, 8'hA2, 0, 0, DEC,   C_NONE,  1);
    step(1, 8'hA2, 0, 0, EXEC,  C_EIMM,  1);
    step(1, 8'hA2, 0, 0, MEM,   C_MST,   1);
    step(1, 8'hA2, 0, 1, MEM,   C_MST,   1);
    step(1, 8'h00, 0, 0, FETCH, C_FWAIT, 2);
`else
    // mem_ack tied low: accesses still complete in one cycle each
    step(1, 8'h00, 0, 0, IDLE,  C_NONE, 0);
    step(1, 8'h00, 0, 0, FETCH, C_FACK, 0);
    step(1, 8'h00, 0, 0, DEC,   C_NONE, 0);
    step(1, 8'h00, 0, 0, EXEC,  C_NONE, 0);
    step(1, 8'h00, 0, 0, WB,    C_WALU, 0);
    step(1, 8'h81, 0, 0, FETCH, C_FACK, 1);
    step(1, 8'h81, 0, 0, DEC,   C_NONE, 1);
    step(1, 8'h81, 0, 0, EXEC,  C_EIMM, 1);
    step(1, 8'h81, 0, 0, MEM,   C_MLD,  1);
    step(1, 8'h81, 0, 0, WB,    C_WLD,  1);
    step(1, 8'hA2, 0, 0, FETCH, C_FACK, 2);
    step(1, 8'hA2, 0, 0, DEC,   C_NONE, 2);
    step(1, 8'hA2, 0, 0, EXEC,  C_EIMM, 2);
    step(1, 8'hA2, 0, 0, MEM,   C_MST,  2);
    step(0, 8'h00, 0, 0, FETCH, C_FACK, 3);
`endif

    // Retire 256 ADDs: the counter wraps back to 0
    do_reset();
    step(1, 8'h00, 0, 1, IDLE, C_NONE, 0);
    for (int k = 0; k < 256; k++) begin
      step(1, 8'h00, 0, 1, FETCH, C_FACK, 8'(k));
      step(1, 8'h00, 0, 0, DEC,   C_NONE, 8'(k));
      step(1, 8'h00, 0, 0, EXEC,  C_NONE, 8'(k));
      step(1, 8'h00, 0, 0, WB,    C_WALU, 8'(k));
    end
    step(0, 8'h00, 0, 1, FETCH, C_FACK, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the 8-bit processor datapath. It steps each instruction through fetch, decode, execute, memory and write-back, and drives the enables and mux selects for the PC, IR, register file, ALU, immediate path and memory port. It sits beside the datapath, reads the current IR contents and the ALU zero flag, and holds no data values itself; the sign-extended 3-bit immediate is formed in the datapath.

## Interface
Parameters:
- CNT_W, 8, width of the retired-instruction counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- run  input  1  level; 1 permits instruction issue
- instr  input  8  IR contents: op[7:5], ra[4:3], imm3[2:0]
- zero  input  1  ALU zero flag, valid in EXEC
- mem_ack  input  1  memory completion for the current mem_req
- pc_we  output  1  PC load enable
- pc_src  output  1  0 = PC+1, 1 = PC+sext(imm3)
- ir_we  output  1  IR load enable
- rf_we  output  1  register-file write enable (dest ra)
- wb_sel  output  1  0 = ALU result, 1 = memory read data
- alu_op  output  2  00 ADD, 01 SUB, 10 AND, 11 PASS-A
- alu_src_imm  output  1  ALU B operand: 0 = reg, 1 = sext(imm3)
- mem_req  output  1  memory request
- mem_we  output  1  memory write (valid with mem_req)
- addr_sel  output  1  memory address: 0 = PC, 1 = ALU result
- halted  output  1  HALT executed
- state  output  3  current FSM state code
- retired  output  CNT_W  instructions completed, wraps

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 ADDI, 100 LD, 101 ST, 110 BEQZ, 111 HALT.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Codes 7, 8+ are unreachable; code 7 → IDLE.
- IDLE: all controls 0. run=1 → FETCH.
- FETCH: mem_req=1, addr_sel=0. When mem_ack=1: ir_we=1, pc_we=1, pc_src=0 → DECODE. Otherwise hold.
- DECODE: no enables → EXEC.
- EXEC:
  - ADD/SUB/AND drive alu_op 00/01/10, alu_src_imm=0 → WB.
  - ADDI drives alu_op=00, alu_src_imm=1 → WB.
  - LD/ST drive alu_op=00, alu_src_imm=1 (address = ra + sext(imm3)) → MEM.
  - BEQZ drives alu_op=11. If zero=1: pc_we=1, pc_src=1. The instruction completes.
  - HALT → HALT; the instruction completes.
- MEM: mem_req=1, addr_sel=1, alu_op=00, alu_src_imm=1, mem_we=(op==ST). On mem_ack: LD → WB; ST completes. Otherwise hold.
- WB: rf_we=1, wb_sel=(op==LD) → completes.
- Completion: retired increments by 1 (mod 2^CNT_W). Next state is FETCH if run=1, else IDLE. The halt-to-HALT transition also increments retired.
- HALT: halted=1, all other enables 0. The state is sticky until rst_n.
- run=0 mid-instruction does not abort. The instruction finishes, then the FSM enters IDLE.
- Branch target is relative to the already-incremented PC.

## Timing
- Enables and selects are combinational from state, instr and mem_ack. They act on the next rising edge.
- mem_ack may arrive in the same cycle mem_req rises (zero-wait). Each extra low cycle adds one cycle of latency.
- Zero-wait latency from FETCH entry to next FETCH entry:
  - ALU/ADDI: 4 cycles
  - LD: 5 cycles
  - ST: 4 cycles
  - BEQZ: 3 cycles
  - HALT: 3 cycles to HALT
- IDLE→FETCH takes 1 cycle after run is sampled high.
- Reset asserted at any point: state=IDLE and retired=0 immediately. All outputs are 0, including halted. There is no pending memory transaction; any in-flight ack is ignored after release.
- First FETCH occurs 1 cycle after the first clk edge with rst_n=1 and run=1.

## Configuration
- MULTICYCLE_MEM_HANDSHAKE_EN defined: FETCH and MEM wait on mem_ack as described.
- Not defined: mem_ack is ignored and treated as 1. FETCH and MEM each take exactly 1 cycle, and mem_req remains a single-cycle strobe per access.

## Test plan
- Reset, then run=1, IR=ADD (0x00), zero-wait ack → FETCH,DECODE,EXEC,WB in 4 cycles. rf_we pulses once with alu_op=00, and retired=1.
- LD 0x81 with mem_ack delayed 2 cycles in MEM → mem_req held 3 cycles with addr_sel=1, mem_we=0. Then WB with wb_sel=1; total 7 cycles.
- BEQZ 0xC7 with zero=1 → pc_we=1, pc_src=1 in EXEC. With zero=0, pc_we=0 in EXEC; both cases return to FETCH after 3 cycles.
- HALT 0xE0 → halted=1 and state=6, held for 20 cycles regardless of run. Then rst_n low → halted=0, state=0, retired=0.
- run dropped during EXEC of ST 0xA2 → MEM completes with mem_we=1, then the FSM enters IDLE with retired incremented.
- With CNT_W=8, retire 256 ADDs → retired wraps to 0. With the macro undefined and mem_ack tied 0, ADD still completes in 4 cycles.
